// File: rtl/spi_xfer_scheduler_if.sv
// ----------------------------------------------------------------------------
// spi_xfer_scheduler_if
// Bundles every non-clock signal of the SPI transfer scheduler.
//   Host run control : enable, wav_period, wav_count, err_clr
//   FIFO status      : wav_empty, cfg_empty
//   Engine handshake : trigger_dac, trigger_config, done, busy
//   Run status       : wav_active, sample_cnt, run_done
//   Sticky errors    : err_underrun, err_missed, err_timeout
// Modports:
//   master - the scheduler itself (drives triggers and status)
//   slave  - its surroundings: host registers, FIFOs and the SPI engine
// ----------------------------------------------------------------------------
interface spi_xfer_scheduler_if #(
    parameter int PER_W = 16,
    parameter int CNT_W = 16
);
    logic             enable;
    logic [PER_W-1:0] wav_period;
    logic [CNT_W-1:0] wav_count;
    logic             wav_empty;
    logic             cfg_empty;
    logic             done;
    logic             err_clr;

    logic             trigger_dac;
    logic             trigger_config;
    logic             busy;
    logic             wav_active;
    logic [CNT_W-1:0] sample_cnt;
    logic             run_done;
    logic             err_underrun;
    logic             err_missed;
    logic             err_timeout;

    modport master (
        input  enable, wav_period, wav_count, wav_empty, cfg_empty, done, err_clr,
        output trigger_dac, trigger_config, busy, wav_active, sample_cnt,
               run_done, err_underrun, err_missed, err_timeout
    );

    modport slave (
        output enable, wav_period, wav_count, wav_empty, cfg_empty, done, err_clr,
        input  trigger_dac, trigger_config, busy, wav_active, sample_cnt,
               run_done, err_underrun, err_missed, err_timeout
    );
endinterface

// File: rtl/spi_xfer_scheduler.sv
// ----------------------------------------------------------------------------
// spi_xfer_scheduler
// Sequences the SPI engine. A programmable sample-period timer raises DAC
// ticks during a waveform run; pending ticks win arbitration over config
// frames, which fill the idle gaps. Each frame is one trigger pulse followed
// by a wait for the engine's done (bounded by TMO cycles) and one gap cycle.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - spi_xfer_scheduler_if.master (run control, FIFO status, engine
//          handshake, run status, sticky errors)
// ----------------------------------------------------------------------------
module spi_xfer_scheduler #(
    parameter int PER_W = 16,
    parameter int CNT_W = 16,
    parameter int TMO   = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_xfer_scheduler_if.master bus
);
    localparam int TMO_W = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t            state, state_nx;
    logic              sel_dac, sel_dac_nx;   // frame kind held through ISSUE
    logic              enable_q;
    logic [PER_W-1:0]  period_lat;
    logic [PER_W-1:0]  tmr_cnt;
    logic [CNT_W-1:0]  count_lat;
    logic [CNT_W-1:0]  sample_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              first_tick;
    logic              tick_pend;
    logic              wav_active;
    logic              last_frame;            // final frame of a finite run in flight
    logic              run_done;
    logic              err_underrun, err_missed, err_timeout;

    logic              rise, tick, issue_dac, final_dac, timeout;
    logic              underrun, gap_entry, tmo_expire;

    assign rise      = bus.enable & ~enable_q;
    assign tick      = wav_active & (first_tick | (tmr_cnt == period_lat - PER_W'(1)));
    assign issue_dac = (state == ISSUE) & sel_dac;
    // The frame that brings sample_cnt up to a non-zero wav_count ends the run.
    assign final_dac = issue_dac & wav_active & (count_lat != '0)
                     & (sample_cnt == count_lat - CNT_W'(1));
    assign timeout    = (tmo_cnt == TMO_W'(TMO));
    assign gap_entry  = (state == WAIT) & (bus.done | timeout);
    assign tmo_expire = (state == WAIT) & timeout & ~bus.done;

    // Arbitration runs in GAP as well as IDLE, which gives the two-cycle
    // done-to-trigger turnaround.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_nx   = state;
        sel_dac_nx = sel_dac;
        underrun   = 1'b0;
        case (state)
            IDLE, GAP: begin
                state_nx = IDLE;
                if (tick_pend && !bus.wav_empty) begin
                    state_nx   = ISSUE;
                    sel_dac_nx = 1'b1;
                end else if (tick_pend) begin
                    underrun = 1'b1;
                end else if (!bus.cfg_empty) begin
                    state_nx   = ISSUE;
                    sel_dac_nx = 1'b0;
                end
            end
            ISSUE:   state_nx = WAIT;
            WAIT:    if (bus.done || timeout) state_nx = GAP;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sel_dac      <= 1'b0;
            enable_q     <= 1'b0;
            period_lat   <= '0;
            tmr_cnt      <= '0;
            count_lat    <= '0;
            sample_cnt   <= '0;
            tmo_cnt      <= '0;
            first_tick   <= 1'b0;
            tick_pend    <= 1'b0;
            wav_active   <= 1'b0;
            last_frame   <= 1'b0;
            run_done     <= 1'b0;
            err_underrun <= 1'b0;
            err_missed   <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            sel_dac  <= sel_dac_nx;
            enable_q <= bus.enable;

            // tmo_cnt equals the number of cycles since the trigger.
            if (state == ISSUE)
                tmo_cnt <= TMO_W'(1);
            else if (state == WAIT && !timeout)
                tmo_cnt <= tmo_cnt + TMO_W'(1);

            if (rise) begin
                wav_active <= 1'b1;
                first_tick <= 1'b1;
                tmr_cnt    <= '0;
                period_lat <= (bus.wav_period == '0) ? PER_W'(1) : bus.wav_period;
                count_lat  <= bus.wav_count;
                sample_cnt <= '0;
            end else begin
                first_tick <= 1'b0;
                if (tick)
                    tmr_cnt <= '0;
                else if (wav_active)
                    tmr_cnt <= tmr_cnt + PER_W'(1);
                if (!bus.enable || final_dac)
                    wav_active <= 1'b0;
                if (issue_dac && sample_cnt != '1)
                    sample_cnt <= sample_cnt + CNT_W'(1);
            end

            // A tick landing on the cycle that consumes the pending one re-arms it.
            if (!bus.enable || final_dac)
                tick_pend <= 1'b0;
            else if (tick)
                tick_pend <= 1'b1;
            else if (issue_dac || underrun)
                tick_pend <= 1'b0;

            if (final_dac)
                last_frame <= 1'b1;
            else if (gap_entry)
                last_frame <= 1'b0;
            run_done <= gap_entry & last_frame;

            if (bus.err_clr) begin
                err_underrun <= 1'b0;
                err_missed   <= 1'b0;
                err_timeout  <= 1'b0;
            end else begin
                if (underrun)
                    err_underrun <= 1'b1;
                if (tick && tick_pend && !issue_dac && !underrun && bus.enable)
                    err_missed <= 1'b1;
                if (tmo_expire)
                    err_timeout <= 1'b1;
            end
        end
    end

    assign bus.trigger_dac    = (state == ISSUE) &  sel_dac;
    assign bus.trigger_config = (state == ISSUE) & ~sel_dac;
    assign bus.busy           = (state != IDLE);
    assign bus.wav_active     = wav_active;
    assign bus.sample_cnt     = sample_cnt;
    assign bus.run_done       = run_done;
    assign bus.err_underrun   = err_underrun;
    assign bus.err_missed     = err_missed;
    assign bus.err_timeout    = err_timeout;
endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// ----------------------------------------------------------------------------
// tb_spi_xfer_scheduler
// Self-checking bench for spi_xfer_scheduler. An event-level reference model
// predicts DAC trigger times from the tick schedule and frame length; an
// automatic engine responder answers each trigger with done after a set delay;
// a negedge monitor logs trigger and run_done cycles.
// Cycle c is the interval following the c-th rising edge; inputs driven at
// the falling edge inside cycle c are those the DUT acts on in cycle c.
// ----------------------------------------------------------------------------
module tb_spi_xfer_scheduler;
    localparam int PER_W = 16;
    localparam int CNT_W = 16;
    localparam int TMO   = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_xfer_scheduler_if #(.PER_W(PER_W), .CNT_W(CNT_W)) bus ();

    spi_xfer_scheduler #(.PER_W(PER_W), .CNT_W(CNT_W), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc       = 0;
    int n_checks  = 0;
    int n_pass    = 0;
    int cfg_level = 0;
    bit auto_done = 1'b0;
    int done_dly  = 1;
    int both_cnt  = 0;
    int dac_q[$];
    int cfg_q[$];
    int rd_q[$];
    int exp_q[$];
    bit exp_missed;

    assign bus.cfg_empty = (cfg_level == 0);

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: logs events and pops the modelled config FIFO.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.trigger_dac) dac_q.push_back(cyc);
            if (bus.trigger_config) begin
                cfg_q.push_back(cyc);
                if (cfg_level > 0) cfg_level--;
            end
            if (bus.trigger_dac && bus.trigger_config) both_cnt++;
            if (bus.run_done) rd_q.push_back(cyc);
        end
    end

    // Engine responder: done is high in cycle (trigger cycle + done_dly).
    initial begin
        int cnt;
        cnt = 0;
        bus.done = 1'b0;
        forever begin
            @(negedge clk);
            bus.done = 1'b0;
            if (rst) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) bus.done = 1'b1;
                end
                if (auto_done && (bus.trigger_dac || bus.trigger_config)) cnt = done_dly;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Event-level model of a DAC-only run: ticks at e+1+j*P; a pending tick is
    // visible the cycle after it fires; the arbitration decision is taken when
    // the scheduler is free (IDLE, or the GAP cycle one past done) and the
    // trigger follows one cycle later. Ticks strictly between the served tick
    // and its trigger are the missed ones.
    function automatic void model_run(input int e, input int p, input int n, input int d);
        int pe, lb, free, j, ts, dec, tr;
        pe = (p == 0) ? 1 : p;
        exp_q.delete();
        exp_missed = 1'b0;
        lb   = e + 1;
        free = 0;
        for (int k = 0; k < n; k++) begin
            j  = (lb - (e + 1) + pe - 1) / pe;
            ts = e + 1 + j * pe;
            dec = (ts + 1 > free) ? ts + 1 : free;
            tr = dec + 1;
            if (ts + pe < tr) exp_missed = 1'b1;
            exp_q.push_back(tr);
            free = tr + d + 1;
            lb   = tr;
        end
    endfunction

    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_trig(input bit dac, input int budget, output int t, output bit ok);
        ok = 1'b0;
        t  = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (dac ? bus.trigger_dac : bus.trigger_config) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
    endtask

    task automatic clear_errors();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
    endtask

    task automatic clear_logs();
        dac_q.delete();
        cfg_q.delete();
        rd_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_trig_dac"}, bus.trigger_dac, 0);
        check({tag, "_trig_cfg"}, bus.trigger_config, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_wav_active"}, bus.wav_active, 0);
        check({tag, "_sample_cnt"}, bus.sample_cnt, 0);
        check({tag, "_run_done"}, bus.run_done, 0);
        check({tag, "_err_underrun"}, bus.err_underrun, 0);
        check({tag, "_err_missed"}, bus.err_missed, 0);
        check({tag, "_err_timeout"}, bus.err_timeout, 0);
    endtask

    task automatic run_case(input string tag, input int p, input int n, input int d);
        int e, last, pe;
        pe = (p == 0) ? 1 : p;
        auto_done = 1'b1;
        done_dly  = d;
        bus.wav_empty = 1'b0;
        cfg_level = 0;
        @(negedge clk);
        clear_logs();
        bus.wav_period = PER_W'(p);
        bus.wav_count  = CNT_W'(n);
        bus.enable     = 1'b1;
        e = cyc;
        model_run(e, p, n, d);
        last = exp_q[n-1];
        wait_cycle(e + 2);
        check({tag, "_active"}, bus.wav_active, 1);
        wait_cycle(last + d + 1 + pe + 5);
        check({tag, "_ndac"}, dac_q.size(), n);
        for (int k = 0; k < n && k < dac_q.size(); k++)
            check($sformatf("%s_t%0d", tag, k), dac_q[k], exp_q[k]);
        check({tag, "_nrd"}, rd_q.size(), 1);
        if (rd_q.size() > 0) check({tag, "_rd_t"}, rd_q[0], last + d + 1);
        check({tag, "_cnt"}, bus.sample_cnt, n);
        check({tag, "_active_end"}, bus.wav_active, 0);
        check({tag, "_missed"}, bus.err_missed, exp_missed);
        check({tag, "_underrun"}, bus.err_underrun, 0);
        check({tag, "_timeout"}, bus.err_timeout, 0);
        check({tag, "_ncfg"}, cfg_q.size(), 0);
        bus.enable = 1'b0;
        clear_errors();
        check({tag, "_clr"}, bus.err_missed, 0);
    endtask

    initial begin : main
        int t, t2, e, d, s, p, nexp;
        bit ok;
        bus.enable     = 1'b0;
        bus.wav_period = '0;
        bus.wav_count  = '0;
        bus.wav_empty  = 1'b0;
        bus.err_clr    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset applied in the very cycle a trigger is issued
        auto_done = 1'b0;
        cfg_level = 1;
        wait_trig(1'b0, 10, t, ok);
        check("rstmid_trig_seen", ok, 1);
        rst = 1'b1;
        #1;
        check_all_zero("rstmid");
        cfg_level = 0;
        repeat (3) @(negedge clk);
        clear_logs();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rstmid_no_cfg", cfg_q.size(), 0);
        check("rstmid_no_dac", dac_q.size(), 0);
        check("rstmid_busy", bus.busy, 0);

        // Paced runs: directed corners, then randomised
        run_case("p100", 100, 4, 45);
        run_case("p30", 30, 4, 45);
        run_case("p0", 0, 3, 4);
        for (int i = 0; i < 6; i++)
            run_case($sformatf("rnd%0d", i), $urandom_range(20, 120),
                     $urandom_range(1, 4), $urandom_range(5, 60));

        // DAC frame cuts into a queue of config frames
        d = $urandom_range(3, 30);
        auto_done = 1'b1;
        done_dly  = d;
        @(negedge clk);
        clear_logs();
        cfg_level = 3;
        bus.wav_period = PER_W'(1000);
        bus.wav_count  = CNT_W'(1);
        bus.enable = 1'b1;
        e = cyc;
        wait_cycle(e + 1 + 4 * (d + 2) + 5);
        check("ilv_ncfg", cfg_q.size(), 3);
        check("ilv_ndac", dac_q.size(), 1);
        if (cfg_q.size() == 3) begin
            check("ilv_cfg0", cfg_q[0], e + 1);
            check("ilv_cfg1", cfg_q[1], e + 1 + 2 * (d + 2));
            check("ilv_cfg2", cfg_q[2], e + 1 + 3 * (d + 2));
        end
        if (dac_q.size() == 1) check("ilv_dac0", dac_q[0], e + 1 + (d + 2));
        check("ilv_nrd", rd_q.size(), 1);
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);

        // Underrun: tick with empty waveform FIFO is dropped
        done_dly = 5;
        @(negedge clk);
        clear_logs();
        bus.wav_empty  = 1'b1;
        bus.wav_period = PER_W'(50);
        bus.wav_count  = '0;
        bus.enable = 1'b1;
        e = cyc;
        wait_cycle(e + 2);
        check("und_pre", bus.err_underrun, 0);
        wait_cycle(e + 3);
        check("und_set", bus.err_underrun, 1);
        wait_cycle(e + 5);
        bus.err_clr = 1'b1;
        wait_cycle(e + 6);
        bus.err_clr   = 1'b0;
        bus.wav_empty = 1'b0;
        check("und_clr", bus.err_underrun, 0);
        check("und_cnt", bus.sample_cnt, 0);
        wait_cycle(e + 50);
        check("und_no_dac", dac_q.size(), 0);
        wait_cycle(e + 60);
        check("und_next_n", dac_q.size(), 1);
        if (dac_q.size() > 0) check("und_next_t", dac_q[0], e + 53);
        check("und_cnt1", bus.sample_cnt, 1);
        bus.enable = 1'b0;
        repeat (10) @(negedge clk);

        // Timeout, then done landing exactly on the timeout cycle
        auto_done = 1'b0;
        clear_logs();
        cfg_level = 1;
        wait_trig(1'b0, 10, t, ok);
        check("tmo_trig_seen", ok, 1);
        wait_cycle(t + TMO);
        check("tmo_pre", bus.err_timeout, 0);
        check("tmo_busy_wait", bus.busy, 1);
        wait_cycle(t + TMO + 1);
        check("tmo_set", bus.err_timeout, 1);
        check("tmo_busy_gap", bus.busy, 1);
        wait_cycle(t + TMO + 2);
        check("tmo_idle", bus.busy, 0);
        clear_errors();
        check("tmo_clr", bus.err_timeout, 0);
        auto_done = 1'b1;
        done_dly  = TMO;
        cfg_level = 1;
        wait_trig(1'b0, 10, t2, ok);
        check("tmo_next_cfg", ok, 1);
        wait_cycle(t2 + TMO + 3);
        check("tmo_edge_noerr", bus.err_timeout, 0);
        check("tmo_edge_idle", bus.busy, 0);

        // Continuous run stopped by enable fall: no run_done, count holds
        p = $urandom_range(20, 60);
        d = $urandom_range(5, 30);
        done_dly = d;
        @(negedge clk);
        clear_logs();
        bus.wav_period = PER_W'(p);
        bus.wav_count  = '0;
        bus.enable = 1'b1;
        e = cyc;
        s = e + $urandom_range(80, 200);
        model_run(e, p, 20, d);
        nexp = 0;
        foreach (exp_q[k]) if (exp_q[k] <= s + 1) nexp++;
        wait_cycle(s);
        bus.enable = 1'b0;
        wait_cycle(s + 80);
        check("stop_ndac", dac_q.size(), nexp);
        for (int k = 0; k < nexp && k < dac_q.size(); k++)
            check($sformatf("stop_t%0d", k), dac_q[k], exp_q[k]);
        check("stop_cnt", bus.sample_cnt, nexp);
        check("stop_nrd", rd_q.size(), 0);
        check("stop_active", bus.wav_active, 0);
        check("stop_busy", bus.busy, 0);

        check("never_both", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
